stack_up_mgr_ingress: RTL and testbench

// - Per-manager ingress buffer on the stack upstream bus, directly feeding one manager's stu__mgr__* port set.
// - Absorbs beats from the stack upstream arbiter into a FWFT FIFO.
// - Returns registered, margin-based backpressure to the stack.
// - Checks SOM/MOM/EOM framing and counts delivered packets.
// - One instance per manager, inside the manager array generate loop.
//

---
 rtl/stack_up_mgr_ingress_pkg.sv | 36 +++
 rtl/stack_up_mgr_ingress_if.sv | 36 +++
 rtl/stu_fwft_fifo.sv | 52 +++++
 rtl/stack_up_mgr_ingress.sv | 124 ++++++++++++
 tb/tb_stack_up_mgr_ingress.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_up_mgr_ingress_pkg.sv
// Shared encodings and default widths for the per-manager stack upstream ingress buffer.
package stack_up_mgr_ingress_pkg;

   localparam int unsigned DefCntlW       = 2;
   localparam int unsigned DefTypeW       = 2;
   localparam int unsigned DefDataW       = 64;
   localparam int unsigned DefOobW        = 32;
   localparam int unsigned DefDepth       = 8;
   localparam int unsigned DefAfullMargin = 2;
   localparam int unsigned PktCntW        = 16;

   typedef enum logic [1:0] {
      CntlSom    = 2'b00,
      CntlMom    = 2'b01,
      CntlEom    = 2'b10,
      CntlSomEom = 2'b11
   } cntl_e;

   // Bit 1 selects data/control, bit 0 selects scalar/vector.
   typedef enum logic [1:0] {
      TypeCtrlVec = 2'b00,
      TypeCtrlScl = 2'b01,
      TypeDataVec = 2'b10,
      TypeDataScl = 2'b11
   } type_e;

   typedef enum logic {
      StIdle  = 1'b0,
      StInPkt = 1'b1
   } frame_state_e;

   function automatic logic is_pkt_end(cntl_e c);
      return (c == CntlEom) || (c == CntlSomEom);
   endfunction

endpackage

// File: rtl/stack_up_mgr_ingress_if.sv
// Valid/ready beat bus used on both the stack side and the manager side of the ingress buffer.
interface stack_up_mgr_ingress_if
   import stack_up_mgr_ingress_pkg::*;
#(
   parameter int unsigned CNTL_W = DefCntlW,
   parameter int unsigned TYPE_W = DefTypeW,
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned OOB_W  = DefOobW
);

   logic              valid;
   logic [CNTL_W-1:0] cntl;
   logic [TYPE_W-1:0] typ;
   logic [DATA_W-1:0] data;
   logic [OOB_W-1:0]  oob_data;
   logic              ready;

   modport master (
      output valid,
      output cntl,
      output typ,
      output data,
      output oob_data,
      input  ready
   );

   modport slave (
      input  valid,
      input  cntl,
      input  typ,
      input  data,
      input  oob_data,
      output ready
   );

endinterface

// File: rtl/stu_fwft_fifo.sv
// First-word-fall-through FIFO: head entry is shown combinationally, pointers carry a wrap bit.
module stu_fwft_fifo #(
   parameter int unsigned WIDTH = 100,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PtrW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_poweron,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [PtrW:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW:0]    wptr_q, wptr_d;
   logic [PtrW:0]    rptr_q, rptr_d;
   logic             push_ok, pop_ok;

   always_comb begin
      empty_o = (wptr_q == rptr_q);
      full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
      pop_ok  = pop_i && !empty_o;
      // A pop in the same edge frees the slot the push lands in.
      push_ok = push_i && (!full_o || pop_ok);
      wptr_d  = wptr_q + (PtrW+1)'(push_ok);
      rptr_d  = rptr_q + (PtrW+1)'(pop_ok);
      count_o = wptr_q - rptr_q;
      rdata_o = empty_o ? '0 : mem_q[rptr_q[PtrW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!reset_poweron) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/stack_up_mgr_ingress.sv
// Per-manager stack upstream ingress: FWFT buffer, registered margin-based ready, framing check
// and packet counter. stk_stu carries the stk__stu__* / stu__stk__ready set, stu_mgr the stu__mgr__*.
module stack_up_mgr_ingress
   import stack_up_mgr_ingress_pkg::*;
#(
   parameter int unsigned CNTL_W       = DefCntlW,
   parameter int unsigned TYPE_W       = DefTypeW,
   parameter int unsigned DATA_W       = DefDataW,
   parameter int unsigned OOB_W        = DefOobW,
   parameter int unsigned DEPTH        = DefDepth,
   parameter int unsigned AFULL_MARGIN = DefAfullMargin
) (
   input  logic                  clk,
   input  logic                  reset_poweron,
   stack_up_mgr_ingress_if.slave  stk_stu,
   stack_up_mgr_ingress_if.master stu_mgr,
   output logic                  stu__sys__frame_err,
   output logic [PktCntW-1:0]    stu__sys__pkt_cnt
);

   localparam int unsigned EntryW = CNTL_W + TYPE_W + DATA_W + OOB_W;
   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam logic [PtrW:0] ReadyLimit = (PtrW+1)'(DEPTH - AFULL_MARGIN);

   frame_state_e        state_q, state_d;
   logic                ready_q, ready_d;
   logic                frame_err_q, frame_err_d;
   logic [PktCntW-1:0]  pkt_cnt_q, pkt_cnt_d;

   logic                beat_hs;
   logic                push, pop;
   logic                pkt_inc;
   cntl_e               beat_cntl;
   logic [EntryW-1:0]   fifo_wdata, fifo_rdata;
   logic                fifo_empty, fifo_full;
   logic [PtrW:0]       fifo_count, occ_next;

   assign fifo_wdata = {stk_stu.cntl, stk_stu.typ, stk_stu.data, stk_stu.oob_data};
   assign beat_cntl  = cntl_e'(stk_stu.cntl[1:0]);
   assign beat_hs    = stk_stu.valid && ready_q;
   assign pop        = !fifo_empty && stu_mgr.ready;

   stu_fwft_fifo #(
      .WIDTH (EntryW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .push_i        (push),
      .wdata_i       (fifo_wdata),
      .pop_i         (pop),
      .rdata_o       (fifo_rdata),
      .empty_o       (fifo_empty),
      .full_o        (fifo_full),
      .count_o       (fifo_count)
   );

   // Framing FSM: only beats that win the stack handshake are classified.
   always_comb begin
      state_d     = state_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
      if (beat_hs) begin
         if (fifo_full && !pop) begin
            frame_err_d = 1'b1;
         end else begin
            unique case (state_q)
               StIdle: begin
                  unique case (beat_cntl)
                     CntlSom: begin
                        push    = 1'b1;
                        state_d = StInPkt;
                     end
                     CntlSomEom: push = 1'b1;
                     CntlMom:    frame_err_d = 1'b1;
                     CntlEom:    frame_err_d = 1'b1;
                  endcase
               end
               StInPkt: begin
                  push = 1'b1;
                  unique case (beat_cntl)
                     CntlMom: state_d = StInPkt;
                     CntlEom: state_d = StIdle;
                     CntlSom: frame_err_d = 1'b1;
                     CntlSomEom: begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                     end
                  endcase
               end
            endcase
         end
      end
   end

   always_comb begin
      pkt_inc   = push && is_pkt_end(beat_cntl);
      pkt_cnt_d = pkt_cnt_q + PktCntW'(pkt_inc);
      occ_next  = fifo_count + (PtrW+1)'(push) - (PtrW+1)'(pop);
      // Registered ready lags a cycle, so leave AFULL_MARGIN slots for the in-flight beat.
      ready_d   = (occ_next <= ReadyLimit);
   end

   always_ff @(posedge clk) begin
      if (!reset_poweron) begin
         state_q     <= StIdle;
         ready_q     <= 1'b0;
         frame_err_q <= 1'b0;
         pkt_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         frame_err_q <= frame_err_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   assign stk_stu.ready = ready_q;
   assign stu_mgr.valid = !fifo_empty;
   assign {stu_mgr.cntl, stu_mgr.typ, stu_mgr.data, stu_mgr.oob_data} = fifo_rdata;
   assign stu__sys__frame_err = frame_err_q;
   assign stu__sys__pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_stack_up_mgr_ingress.sv
// Scoreboard bench for stack_up_mgr_ingress: a framing model fills the expected-beat queue on each
// stack handshake; manager handshakes pop and compare; err/pkt/ready/valid are checked every cycle.
module tb_stack_up_mgr_ingress;
   import stack_up_mgr_ingress_pkg::*;

   localparam int unsigned ReadyLimit = DefDepth - DefAfullMargin;

   logic clk = 1'b0;
   logic reset_poweron;
   logic        frame_err;
   logic [15:0] pkt_cnt;

   stack_up_mgr_ingress_if stk_if ();
   stack_up_mgr_ingress_if mgr_if ();

   stack_up_mgr_ingress u_dut (
      .clk                 (clk),
      .reset_poweron       (reset_poweron),
      .stk_stu             (stk_if),
      .stu_mgr             (mgr_if),
      .stu__sys__frame_err (frame_err),
      .stu__sys__pkt_cnt   (pkt_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard and reference model state, owned by the monitor.
   logic [99:0] sb[$];
   logic        m_in_pkt = 1'b0;
   logic [15:0] m_pkt = '0;
   logic [15:0] exp_pkt = '0;
   logic        exp_err = 1'b0;
   logic        exp_ready_zero = 1'b1;
   int          popped = 0;
   int          err_seen = 0;
   logic        m_write, m_err;
   logic [1:0]  m_c;
   logic [99:0] head;

   always @(negedge clk) begin
      check_eq("frame_err", frame_err, exp_err);
      check_eq("pkt_cnt", pkt_cnt, exp_pkt);
      check_eq("stk_ready", stk_if.ready,
               exp_ready_zero ? 1'b0 : (sb.size() <= ReadyLimit));
      check_eq("mgr_valid", mgr_if.valid, sb.size() != 0);
      if (frame_err === 1'b1) err_seen++;
      if (!reset_poweron) begin
         sb.delete();
         m_in_pkt       = 1'b0;
         m_pkt          = '0;
         exp_pkt        = '0;
         exp_err        = 1'b0;
         exp_ready_zero = 1'b1;
      end else begin
         exp_ready_zero = 1'b0;
         exp_err        = 1'b0;
         if (mgr_if.valid && mgr_if.ready && sb.size() != 0) begin
            head = sb.pop_front();
            check_eq("head_beat", {mgr_if.cntl, mgr_if.typ, mgr_if.data, mgr_if.oob_data}, head);
            popped++;
         end
         if (stk_if.valid && stk_if.ready) begin
            m_c     = stk_if.cntl;
            m_write = 1'b1;
            m_err   = 1'b0;
            if (!m_in_pkt) begin
               if (m_c == CntlMom || m_c == CntlEom) begin
                  m_write = 1'b0;
                  m_err   = 1'b1;
               end else begin
                  m_in_pkt = (m_c == CntlSom);
               end
            end else begin
               m_err    = (m_c == CntlSom) || (m_c == CntlSomEom);
               m_in_pkt = (m_c == CntlSom) || (m_c == CntlMom);
            end
            if (m_write) sb.push_back({stk_if.cntl, stk_if.typ, stk_if.data, stk_if.oob_data});
            if (m_write && (m_c == CntlEom || m_c == CntlSomEom)) m_pkt = m_pkt + 16'd1;
            exp_err = m_err;
            exp_pkt = m_pkt;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [1:0] c, input logic [63:0] d);
      stk_if.valid    = 1'b1;
      stk_if.cntl     = c;
      stk_if.typ      = 2'($urandom);
      stk_if.data     = d;
      stk_if.oob_data = $urandom;
   endtask

   // Returns #1 after the accepting edge; valid stays up so beats can go back to back.
   task automatic wait_accept(output int used);
      logic ok;
      ok   = 1'b0;
      used = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (stk_if.ready) ok = 1'b1;
         @(posedge clk);
         #1;
         used++;
      end
      check_eq("accept_in_budget", ok, 1'b1);
   endtask

   task automatic send(input logic [1:0] c, input logic [63:0] d);
      int used;
      drive(c, d);
      wait_accept(used);
   endtask

   task automatic idle();
      stk_if.valid = 1'b0;
      cycles(1);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && mgr_if.valid; i++) cycles(1);
      check_eq("drained", mgr_if.valid, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   int p0, e0, c0, used, total;

   initial begin
      reset_poweron   = 1'b0;
      stk_if.valid    = 1'b0;
      stk_if.cntl     = '0;
      stk_if.typ      = '0;
      stk_if.data     = '0;
      stk_if.oob_data = '0;
      mgr_if.ready    = 1'b0;
      cycles(3);
      check_eq("rst_valid", mgr_if.valid, 1'b0);
      check_eq("rst_ready", stk_if.ready, 1'b0);
      check_eq("rst_pkt", pkt_cnt, 16'd0);
      check_eq("rst_err", frame_err, 1'b0);
      check_eq("rst_data", {mgr_if.cntl, mgr_if.typ, mgr_if.data, mgr_if.oob_data}, 100'd0);
      reset_poweron = 1'b1;
      cycles(1);
      check_eq("ready_after_rst", stk_if.ready, 1'b1);

      // Basic 3-beat packet.
      mgr_if.ready = 1'b1;
      p0 = popped; e0 = err_seen;
      send(CntlSom, 64'h11);
      send(CntlMom, 64'h22);
      send(CntlEom, 64'h33);
      idle();
      cycles(3);
      check_eq("pkt3_cnt", pkt_cnt, 16'd1);
      check_eq("pkt3_delivered", popped - p0, 3);
      check_eq("pkt3_no_err", err_seen - e0, 0);

      // Backpressure: manager stalled, stack streams.
      mgr_if.ready = 1'b0;
      p0 = popped;
      send(CntlSom, 64'h100);
      for (int i = 1; i < 7; i++) send(CntlMom, 64'h100 + 64'(i));
      drive(CntlMom, 64'h107);
      cycles(5);
      check_eq("bp_ready_low", stk_if.ready, 1'b0);
      check_eq("bp_held", sb.size(), 7);
      check_eq("bp_none_popped", popped - p0, 0);
      mgr_if.ready = 1'b1;
      wait_accept(used);
      send(CntlEom, 64'h108);
      idle();
      drain();
      check_eq("bp_all_delivered", popped - p0, 9);
      check_eq("bp_pkt", pkt_cnt, 16'd2);

      // Stray MOM in IDLE is dropped with one error pulse; FSM stays IDLE.
      p0 = popped; e0 = err_seen;
      send(CntlMom, 64'hAA);
      idle();
      cycles(3);
      check_eq("mom_dropped", popped - p0, 0);
      check_eq("mom_err_pulse", err_seen - e0, 1);
      send(CntlSomEom, 64'hBB);
      idle();
      cycles(3);
      check_eq("mom_then_single", err_seen - e0, 1);
      check_eq("mom_single_pkt", pkt_cnt, 16'd3);

      // SOM, MOM, SOM_EOM: all delivered, one error, packet closed.
      p0 = popped; e0 = err_seen;
      send(CntlSom, 64'hC1);
      send(CntlMom, 64'hC2);
      send(CntlSomEom, 64'hC3);
      idle();
      cycles(3);
      check_eq("se_delivered", popped - p0, 3);
      check_eq("se_err", err_seen - e0, 1);
      check_eq("se_pkt", pkt_cnt, 16'd4);
      send(CntlSomEom, 64'hC4);
      idle();
      cycles(3);
      check_eq("se_idle_after", err_seen - e0, 1);
      check_eq("se_pkt2", pkt_cnt, 16'd5);

      // Steady push+pop at the ready limit across pointer wrap.
      mgr_if.ready = 1'b0;
      send(CntlSom, 64'h200);
      for (int i = 1; i < 6; i++) send(CntlMom, 64'h200 + 64'(i));
      mgr_if.ready = 1'b1;
      p0 = popped; total = 0;
      for (int i = 0; i < 20; i++) begin
         drive(CntlMom, 64'h300 + 64'(i));
         wait_accept(used);
         total += used;
      end
      check_eq("steady_no_stall", total, 20);
      check_eq("steady_popped", popped - p0, 20);
      send(CntlEom, 64'h3FF);
      idle();
      drain();
      check_eq("steady_pkt", pkt_cnt, 16'd6);

      // Reset mid-packet with 2 beats buffered.
      mgr_if.ready = 1'b0;
      e0 = err_seen;
      send(CntlSom, 64'h400);
      send(CntlMom, 64'h401);
      stk_if.valid  = 1'b0;
      reset_poweron = 1'b0;
      cycles(1);
      check_eq("mid_rst_valid", mgr_if.valid, 1'b0);
      check_eq("mid_rst_pkt", pkt_cnt, 16'd0);
      reset_poweron = 1'b1;
      cycles(1);
      check_eq("mid_rst_ready", stk_if.ready, 1'b1);
      mgr_if.ready = 1'b1;
      p0 = popped;
      send(CntlSomEom, 64'hCC);
      idle();
      cycles(3);
      check_eq("post_rst_pkt", pkt_cnt, 16'd1);
      check_eq("post_rst_delivered", popped - p0, 1);
      check_eq("post_rst_no_err", err_seen - e0, 0);

      cycles(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
